// File: rtl/axi_resp_merge_arbiter_if.sv
// Handshake bundle between the slave-side response buffers, the response
// packetizer and the B/R merge arbiter.
interface axi_resp_merge_arbiter_if;
    logic       b_valid;
    logic       r_valid;
    logic       r_last;
    logic [1:0] release_trans;
    logic [1:0] active_channel;
    logic       locked;

    // Arbiter side
    modport master (
        input  b_valid,
        input  r_valid,
        input  r_last,
        input  release_trans,
        output active_channel,
        output locked
    );

    // Response buffers / packetizer side
    modport slave (
        output b_valid,
        output r_valid,
        output r_last,
        output release_trans,
        input  active_channel,
        input  locked
    );
endinterface

// File: rtl/axi_resp_merge_arbiter.sv
// Round-robin arbiter sharing the response packetizer between the AXI B and
// R channels, with grant hold under back-pressure and optional read-burst lock.
module axi_resp_merge_arbiter #(
    parameter int LOCK_READ_BURST = 1,
    parameter int MAX_LOCK_BEATS  = 16
) (
    input logic                      clk,
    input logic                      rst,
    axi_resp_merge_arbiter_if.master bus
);

    localparam int CNT_W = ((MAX_LOCK_BEATS <= 1) ? 1 : $clog2(MAX_LOCK_BEATS)) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK_BEATS);
    // Every R release ends the transaction when locking is off or capped at one beat
    localparam bit NO_LOCK = (LOCK_READ_BURST == 0) || (MAX_LOCK_BEATS == 1);
    localparam bit CAP_EN  = (MAX_LOCK_BEATS != 0);

    typedef enum logic [1:0] {ARB, HOLD_B, HOLD_R, LOCK_R} state_t;
    typedef enum logic {PRIO_B, PRIO_R} prio_t;

    state_t           state_q, state_d;
    prio_t            prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             gnt_b, gnt_r;
    logic             rel_b, rel_r;

    // State, priority and lock beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            prio_q  <= PRIO_B;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: only releases of the granted, valid channel are accepted
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        rel_b   = gnt_b & bus.b_valid & bus.release_trans[0];
        rel_r   = gnt_r & bus.r_valid & bus.release_trans[1];
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            ARB, HOLD_B, HOLD_R: begin
                if (rel_b) begin
                    state_d = ARB;
                    prio_d  = PRIO_R;
                end else if (rel_r) begin
                    if (bus.r_last || NO_LOCK) begin
                        state_d = ARB;
                        prio_d  = PRIO_B;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOCK_R;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (state_q == ARB) begin
                    if (gnt_b)
                        state_d = HOLD_B;
                    else if (gnt_r)
                        state_d = HOLD_R;
                end
            end
            LOCK_R: begin
                if (rel_r) begin
                    if (bus.r_last || (CAP_EN && (cnt_inc == MAX_CNT))) begin
                        state_d = ARB;
                        prio_d  = PRIO_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Outputs: grant from state/prio/valids only, masked by valid and reset
    always_comb begin
        gnt_b = 1'b0;
        gnt_r = 1'b0;
        case (state_q)
            ARB: begin
                if (prio_q == PRIO_B) begin
                    if (bus.b_valid)
                        gnt_b = 1'b1;
                    else if (bus.r_valid)
                        gnt_r = 1'b1;
                end else begin
                    if (bus.r_valid)
                        gnt_r = 1'b1;
                    else if (bus.b_valid)
                        gnt_b = 1'b1;
                end
            end
            HOLD_B:  gnt_b = 1'b1;
            default: gnt_r = 1'b1;
        endcase
        bus.active_channel = rst ? 2'b00 : {gnt_r & bus.r_valid, gnt_b & bus.b_valid};
        bus.locked         = !rst && (state_q == LOCK_R);
    end

endmodule

// File: doc/axi_resp_merge_arbiter.md
# axi_resp_merge_arbiter

Arbitration controller in the Master NI that shares the response packetizer between the AXI Write Response (B) and Read Data (R) channels of the attached External Slave. It drives the packetizer's one-hot `active_channel` select and consumes its `release_trans` acknowledgements. It runs round-robin between B and R, holds a grant stable while the packetizer back-pressures, and can lock the packetizer to R for the length of a read burst, with a bounded lock length.

## Interface
Parameters:
- `LOCK_READ_BURST`, default 1: 1 keeps R granted from the first beat until LAST; 0 re-arbitrates after every R beat.
- `MAX_LOCK_BEATS`, default 16: maximum R beats per lock, LAST included; 0 means unlimited. Minimum nonzero value is 1.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `b_valid`  in  1  B channel valid from slave-side response buffer.
- `r_valid`  in  1  R channel valid from slave-side response buffer.
- `r_last`  in  1  RLAST of the current R beat; qualified by `r_valid`.
- `release_trans`  in  2  from packetizer; bit0 = B beat consumed, bit1 = R beat consumed.
- `active_channel`  out  2  one-hot select to packetizer; bit0 = write (B), bit1 = read (R); never 2'b11.
- `locked`  out  1  status; high while in LOCK_R.

## Operation
- Registers:
  - `state` ∈ {ARB, HOLD_B, HOLD_R, LOCK_R}.
  - `prio` ∈ {B, R}.
  - `beat_cnt`, width log2c_1if1(MAX_LOCK_BEATS)+1.
- Combinational grant:
  - ARB: grant `prio` if its valid is high, else the other channel if its valid is high, else none.
  - HOLD_B: grant B. HOLD_R and LOCK_R: grant R.
  - `active_channel` = onehot(grant) & {r_valid, b_valid}.
  - Forced to 2'b00 while `rst` is high.
- Accepted release: `release_trans` bit that matches the granted, valid channel. Any other `release_trans` bit is ignored. The bench flags it with an assertion.
- Transitions:
  - ARB, grant present, no release → HOLD_<granted>. This keeps AXI valid/grant stable under back-pressure.
  - ARB or HOLD_B, B released → ARB, `prio` <= R.
  - ARB or HOLD_R, R released:
    - If `r_last`, or `LOCK_READ_BURST`=0, or `MAX_LOCK_BEATS`=1: → ARB, `prio` <= B, `beat_cnt` <= 0.
    - Otherwise: → LOCK_R, `beat_cnt` <= 1.
  - LOCK_R, R released:
    - `beat_cnt`+1 increments.
    - If `r_last`, or `beat_cnt`+1 == MAX_LOCK_BEATS (nonzero): → ARB, `prio` <= B, `beat_cnt` <= 0.
  - LOCK_R, `r_valid` low: stay in LOCK_R. B is not granted even if `b_valid` is high.
  - HOLD_x, no release: stay.
- The counter saturates at MAX_LOCK_BEATS; when MAX_LOCK_BEATS=0 it does not wrap-check.

## Timing
- Reset values:
  - `state`=ARB, `prio`=B, `beat_cnt`=0, `locked`=0.
  - `active_channel`=2'b00 during reset, and after reset while both valids are low.
- Grant latency is zero cycles. `active_channel` follows valid in the same cycle; there is no combinational path from `release_trans` to `active_channel`.
- Register updates take effect on the edge after the release cycle. Back-to-back releases on consecutive cycles sustain full throughput with no bubble cycles.
- Simultaneous `b_valid` and `r_valid` in ARB: `prio` decides the grant.
- Valid drop without release is an illegal AXI source behaviour. In HOLD_x, `active_channel` drops to 00 and the block stays in HOLD_x.
- Reset asserted mid-hold or mid-lock: the next cycle is the ARB reset state; the partial burst count is discarded.

## Test plan
- **Reset:** `rst`=1 with `b_valid`=`r_valid`=1 → `active_channel`=00, `locked`=0. First cycle after reset → `active_channel`=01 (prio B).
- **Round-robin, LOCK=0:** B and R continuously valid, `release_trans` always equals `active_channel` → grants alternate 01,10,01,10 every cycle.
- **Hold:** prio=R, only B valid → `active_channel`=01. R rises while `release_trans`=00 for 3 cycles → 01 is held all 3 cycles. On the B release → next cycle 10.
- **Burst lock, LOCK=1, MAX=16:** 4-beat R burst, `r_last` on beat 4, `b_valid`=1 throughout → `active_channel`=10 for 4 releases, `locked`=1 during beats 2–4. The cycle after LAST → 01.
- **Lock cap, MAX=2:** 5-beat burst with B pending → sequence R,R,B,R,R,B,R.
- **Lock gap:** 4-beat burst with `r_valid` low for 2 cycles after beat 2 → `active_channel`=00 for those 2 cycles while `b_valid`=1, `locked` stays 1, and the burst resumes on R.
